// File: rtl/apb_arb_pkg.sv
// Shared types and the round-robin pick rule for the two-requester APB master.
package apb_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_st_t;

    localparam int NREQ = 2;

    // With both requesters pending, the one that did not win last time goes next.
    function automatic logic rr_pick(input logic [NREQ-1:0] valid, input logic last);
        if (&valid) begin
            return ~last;
        end
        return valid[1];
    endfunction

endpackage

// File: rtl/apb_arb_rr.sv
// Round-robin arbiter: combinational winner plus the last-grant history register.
module apb_arb_rr
    import apb_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            load,
    output logic            winner
);

    logic last_grant;

    assign winner = rr_pick(valid, last_grant);

    // Reset value 1 makes requester 0 the first winner on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (load) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, completion return.
// Define APB_ARB_TIMEOUT_EN to force an error completion after TIMEOUT unready ACCESS cycles.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_write,
    input  logic [2*AWIDTH-1:0] req_addr,
    input  logic [2*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]     req_done,
    output logic [DWIDTH-1:0]   req_rdata,
    output logic                req_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [AWIDTH-1:0]   PADDR,
    output logic [DWIDTH-1:0]   PWDATA,
    input  logic [DWIDTH-1:0]   PRDATA,
    input  logic                PREADY
);

    apb_st_t state, state_nxt;
    logic    gnt;
    logic    winner;
    logic    start;
    logic    finish;
    logic    expire;

    assign start = (state == ST_IDLE) && (req_valid != '0);

    apb_arb_rr u_rr (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .valid  (req_valid),
        .load   (start),
        .winner (winner)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Expiry only counts when PREADY is low, so a late PREADY still completes normally.
    assign expire = (state == ST_ACCESS) && !PREADY && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign expire         = 1'b0;
`endif

    assign finish = (state == ST_ACCESS) && (PREADY || expire);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (finish) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // APB strobes follow the next state so they are clean flop outputs; address/data latch at grant.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            gnt     <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            PSEL    <= (state_nxt != ST_IDLE);
            PENABLE <= (state_nxt == ST_ACCESS);
            if (start) begin
                gnt    <= winner;
                PWRITE <= req_write[winner];
                PADDR  <= winner ? req_addr[2*AWIDTH-1:AWIDTH]  : req_addr[AWIDTH-1:0];
                PWDATA <= winner ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];
            end
        end
    end

    assign req_done  = finish ? (NREQ'(1) << gnt) : '0;
    assign req_err   = finish && expire;
    assign req_rdata = (finish && !PWRITE && !req_err) ? PRDATA : '0;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed vector table, corner sequences, random vs. model.
module tb_apb_master_arb;

    localparam int AW = 8;
    localparam int DW = 32;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_done;
    logic [DW-1:0]   req_rdata;
    logic            req_err;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;

    int total = 0;
    int bad   = 0;

    apb_master_arb #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(4)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave: register file with a per-transfer wait count latched in SETUP.
    logic [DW-1:0] slave_mem [256];
    int            acc_cnt;
    int            wait_lat;
    int            wait_cfg;
    bit            force_en;
    bit            force_val;

    assign PREADY = force_en ? force_val : (acc_cnt >= wait_lat);
    assign PRDATA = slave_mem[PADDR];

    always @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= '0;
            acc_cnt  <= 0;
            wait_lat <= 0;
        end else begin
            if (PSEL && !PENABLE) begin
                wait_lat <= wait_cfg;
                acc_cnt  <= 0;
            end else if (PSEL && PENABLE && !PREADY) begin
                acc_cnt <= acc_cnt + 1;
            end else begin
                acc_cnt <= 0;
            end
            if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
        end
    end

    typedef struct {
        int          r;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        int          w;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] model_mem [256];
    bit          prev_setup;
    logic [1:0]  exp_done;
    bit          pend [2];
    bit          p_wr [2];
    logic [7:0]  p_a  [2];
    logic [31:0] p_d  [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic v;
        @(negedge PCLK);
        v = (PENABLE && !PSEL) || (prev_setup && PSEL && !PENABLE) ||
            ((req_done == 2'b00) && (req_rdata != '0)) ||
            ((req_done != 2'b00) && !(PSEL && PENABLE));
        chk("protocol", {63'd0, v}, 64'd0);
        prev_setup = PSEL && !PENABLE;
    endtask

    task automatic do_reset();
        PRESETn   = 1'b0;
        req_valid = 2'b00;
        force_en  = 1'b0;
        wait_cfg  = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("reset_ctrl", {PSEL, PENABLE, PWRITE, req_done, req_err}, 6'd0);
        chk("reset_data", {PADDR, PWDATA}, 40'd0);
        chk("reset_rdata", req_rdata, 32'd0);
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        prev_setup = 1'b0;
        PRESETn    = 1'b1;
    endtask

    task automatic set_req(input int r, input bit wr, input logic [7:0] a, input logic [31:0] d);
        req_write[r]           = wr;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
    endtask

    task automatic do_xfer(input int r, input bit wr, input logic [7:0] a,
                           input logic [31:0] d, input int w, input logic [31:0] exp);
        logic [1:0] ed;
        wait_cfg = w;
        set_req(r, wr, a, d);
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        tick();
        chk("setup_phase", {PSEL, PENABLE, req_done}, 4'b1000);
        chk("setup_addr", {PWRITE, PADDR}, {wr, a});
        if (wr) chk("setup_wdata", PWDATA, d);
        for (int i = 0; i < w; i++) begin
            tick();
            chk("wait_phase", {PSEL, PENABLE, req_done}, 4'b1100);
        end
        tick();
        ed    = 2'b00;
        ed[r] = 1'b1;
        chk("done", {PSEL, PENABLE, req_done, req_err}, {2'b11, ed, 1'b0});
        chk("rdata", req_rdata, wr ? 32'd0 : exp);
        req_valid = 2'b00;
        tick();
        chk("idle_after", {PSEL, PENABLE, req_done, PADDR}, {4'b0000, a});
    endtask

    task automatic new_req(input int i);
        p_wr[i] = 1'($urandom_range(0, 1));
        p_a[i]  = 8'($urandom_range(0, 15));
        p_d[i]  = $urandom;
        pend[i] = 1'b1;
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = pend[i];
            set_req(i, p_wr[i], p_a[i], p_d[i]);
        end
    endtask

    initial begin
        int  lat;
        int  exp_lat;
        int  w;
        int  last;
        int  win;
        bit  got;
        bit  stable;

        PRESETn   = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        force_en  = 1'b0;
        force_val = 1'b0;
        wait_cfg  = 0;

        vecs[0] = '{0, 1'b1, 8'h04, 32'hA5A5A5A5, 0, 32'h0};
        vecs[1] = '{1, 1'b0, 8'h04, 32'h0,        0, 32'hA5A5A5A5};
        vecs[2] = '{1, 1'b1, 8'h10, 32'h12345678, 1, 32'h0};
        vecs[3] = '{0, 1'b0, 8'h10, 32'h0,        2, 32'h12345678};
        vecs[4] = '{0, 1'b1, 8'hFF, 32'hFFFFFFFF, 0, 32'h0};
        vecs[5] = '{1, 1'b0, 8'hFF, 32'h0,        3, 32'hFFFFFFFF};
        vecs[6] = '{0, 1'b0, 8'h20, 32'h0,        0, 32'h0};
        vecs[7] = '{1, 1'b1, 8'h00, 32'h0BADF00D, 2, 32'h0};

        do_reset();
        for (int i = 0; i < 8; i++)
            do_xfer(vecs[i].r, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].w, vecs[i].exp);

`ifdef APB_ARB_TIMEOUT_EN
        force_en  = 1'b1;
        force_val = 1'b0;
        set_req(0, 1'b0, 8'h04, 32'h0);
        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tmo_wait", {PSEL, PENABLE, req_done, req_err}, 5'b11000);
        end
        tick();
        chk("tmo_expire", {req_done, req_err}, 3'b011);
        chk("tmo_rdata", req_rdata, 32'd0);
        req_valid = 2'b00;
        tick();
        chk("tmo_idle", {PSEL, PENABLE, req_done}, 4'b0000);

        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 4; k++) tick();
        force_val = 1'b1;
        #1;
        chk("tmo_late_ready", {req_done, req_err}, 3'b010);
        chk("tmo_late_rdata", req_rdata, 32'hA5A5A5A5);
        req_valid = 2'b00;
        force_en  = 1'b0;
        tick();
        chk("tmo_late_idle", {PSEL, PENABLE, req_done}, 4'b0000);
`else
        force_en  = 1'b1;
        force_val = 1'b0;
        set_req(0, 1'b1, 8'h55, 32'hDEADBEEF);
        req_valid = 2'b01;
        tick();
        tick();
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!(PSEL && PENABLE && PWRITE && (req_done == 2'b00) && !req_err &&
                  (PADDR == 8'h55) && (PWDATA == 32'hDEADBEEF))) stable = 1'b0;
        end
        chk("hang_stable", {63'd0, stable}, 64'd1);
        force_val = 1'b1;
        #1;
        chk("hang_release", {req_done, req_err}, 3'b010);
        req_valid = 2'b00;
        force_en  = 1'b0;
        tick();
        chk("hang_idle", {PSEL, PENABLE, req_done}, 4'b0000);
        do_xfer(1, 1'b0, 8'h55, 32'h0, 1, 32'hDEADBEEF);
`endif

        // Both requesters held from reset: strict alternation starting at requester 0.
        do_reset();
        set_req(0, 1'b1, 8'h30, 32'h00000030);
        set_req(1, 1'b1, 8'h31, 32'h00000031);
        wait_cfg  = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                lat++;
                if (req_done != 2'b00) got = 1'b1;
            end
            chk("rr_seen", {63'd0, got}, 64'd1);
            chk("rr_order", req_done, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_gap", lat, (k == 0) ? 2 : 3);
        end
        req_valid = 2'b00;
        tick();
        do_xfer(0, 1'b1, 8'h40, 32'h40404040, 0, 32'h0);

        // Abort a requester-0 transfer mid-ACCESS; requester 0 must win first again afterwards.
        wait_cfg  = 5;
        set_req(0, 1'b0, 8'h40, 32'h0);
        req_valid = 2'b01;
        tick();
        tick();
        chk("abort_pre", {PSEL, PENABLE, req_done}, 4'b1100);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("abort_async", {PSEL, PENABLE, req_done}, 4'b0000);
        req_valid = 2'b11;
        wait_cfg  = 0;
        set_req(0, 1'b1, 8'h50, 32'h50505050);
        set_req(1, 1'b1, 8'h51, 32'h51515151);
        @(negedge PCLK);
        chk("abort_hold", {PSEL, PENABLE, req_done}, 4'b0000);
        @(negedge PCLK);
        prev_setup = 1'b0;
        PRESETn    = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            lat++;
            if (req_done != 2'b00) got = 1'b1;
        end
        chk("abort_regrant", req_done, 2'b01);
        chk("abort_latency", lat, 2);
        req_valid = 2'b00;
        tick();

        // Random traffic against a transaction-level model.
        do_reset();
        last = 1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        new_req($urandom_range(0, 1));
        for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
        w        = $urandom_range(0, 3);
        wait_cfg = w;
        apply_reqs();
        exp_lat = 2 + w;
        for (int n = 0; n < 150; n++) begin
            lat = 0;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                lat++;
                if (req_done != 2'b00) got = 1'b1;
            end
            chk("rand_seen", {63'd0, got}, 64'd1);
            if (!got) break;
            chk("rand_latency", lat, exp_lat);
            win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            exp_done      = 2'b00;
            exp_done[win] = 1'b1;
            chk("rand_grant", {req_done, req_err}, {exp_done, 1'b0});
            chk("rand_addr", {PWRITE, PADDR}, {p_wr[win], p_a[win]});
            if (p_wr[win]) begin
                chk("rand_wdata", PWDATA, p_d[win]);
                chk("rand_wr_rdata", req_rdata, 32'd0);
                model_mem[p_a[win]] = p_d[win];
            end else begin
                chk("rand_rdata", req_rdata, model_mem[p_a[win]]);
            end
            last      = win;
            pend[win] = 1'b0;
            for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
            w        = $urandom_range(0, 3);
            wait_cfg = w;
            apply_reqs();
            exp_lat = 3 + w;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
